// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial word receiver: state encoding and default word width.
package shift_rx_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } rx_state_e;

endpackage

// File: rtl/shift_word_receiver_bit_counter.sv
// Up-counter of received bits with synchronous clear/enable and a terminal flag at WIDTH-1.
module bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     terminal
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/shift_word_receiver.sv
// Serial-in, parallel-out word receiver with a valid/ready holding register.
// Define RX_PARITY_CHECK_EN to expect an even-parity bit after each data word.
module shift_word_receiver
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             msb_first,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CntW = $clog2(WIDTH);

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic             dir_q, dir_d;
  logic [CntW-1:0]  count;
  logic             terminal;
  logic             cnt_clear, accept_bit;

  logic             write_en;
  logic [WIDTH-1:0] write_word;
  logic             write_drop;

  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (accept_bit),
    .count   (count),
    .terminal(terminal)
  );

  assign shifted = dir_q ? {sreg_q[WIDTH-2:0], bit_in} : {bit_in, sreg_q[WIDTH-1:1]};

`ifdef RX_PARITY_CHECK_EN
  logic write_par;
  logic parity_q;
`endif

  // Frame sequencing; start always wins and restarts the frame from scratch.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    dir_d      = dir_q;
    cnt_clear  = 1'b0;
    accept_bit = 1'b0;
    write_en   = 1'b0;
    write_word = shifted;
`ifdef RX_PARITY_CHECK_EN
    write_par  = 1'b0;
`endif
    if (start) begin
      state_d   = StShift;
      sreg_d    = '0;
      dir_d     = msb_first;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StShift: begin
          if (bit_valid) begin
            accept_bit = 1'b1;
            sreg_d     = shifted;
            if (terminal) begin
`ifdef RX_PARITY_CHECK_EN
              state_d = StParity;
`else
              state_d  = StIdle;
              write_en = 1'b1;
`endif
            end
          end
        end
`ifdef RX_PARITY_CHECK_EN
        StParity: begin
          if (bit_valid) begin
            state_d    = StIdle;
            write_en   = 1'b1;
            write_word = sreg_q;
            write_par  = ^{sreg_q, bit_in};
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // A completed word is dropped only if the held word is still unconsumed this cycle.
  assign write_drop = word_valid_q && !word_ready;

  always_comb begin
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
    if (write_en) begin
      if (write_drop) begin
        overrun_d = 1'b1;
      end else begin
        word_out_d   = write_word;
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      dir_q        <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      dir_q        <= dir_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= (state_d != StIdle);
    end
  end

`ifdef RX_PARITY_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (write_en && !write_drop) begin
      parity_q <= write_par;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_word_receiver.sv
// Directed bench for shift_word_receiver with a per-cycle behavioural model and literal checks.
module tb_shift_word_receiver;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         msb_first = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

`ifdef RX_PARITY_CHECK_EN
  bit par_flip = 1'b0;
`endif

  shift_word_receiver #(
    .WIDTH(W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .msb_first (msb_first),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  // Behavioural model: frame as a bit count plus an arithmetic accumulator.
  bit          m_active, m_par_phase, m_dir;
  int          m_n;
  logic [31:0] m_acc;
  logic [W-1:0] m_word;
  bit          m_valid, m_overrun, m_perr, m_busy;

  always @(posedge clock) begin
    bit          do_write, accept, p;
    logic [31:0] w;
    do_write = 1'b0;
    p = 1'b0;
    w = '0;
    if (reset) begin
      m_active = 0; m_par_phase = 0; m_dir = 0; m_n = 0; m_acc = '0;
      m_word = '0; m_valid = 0; m_overrun = 0; m_perr = 0; m_busy = 0;
    end else begin
      accept = m_valid && word_ready;
      if (start) begin
        m_active = 1; m_par_phase = 0; m_n = 0; m_acc = '0; m_dir = msb_first;
      end else if (m_par_phase) begin
        if (bit_valid) begin
          do_write = 1;
          w = m_acc;
          p = ($countones(m_acc) + int'(bit_in)) % 2 == 1;
          m_par_phase = 0;
          m_active = 0;
        end
      end else if (m_active && bit_valid) begin
        if (m_dir) m_acc = m_acc * 2 + 32'(bit_in);
        else       m_acc = m_acc + (32'(bit_in) << m_n);
        m_n++;
        if (m_n == W) begin
`ifdef RX_PARITY_CHECK_EN
          m_par_phase = 1;
`else
          do_write = 1;
          w = m_acc;
          m_active = 0;
`endif
        end
      end
      if (do_write) begin
        if (m_valid && !word_ready) begin
          m_overrun = 1;
        end else begin
          m_word = w[W-1:0];
          m_perr = p;
          m_valid = 1;
          accept = 0;
        end
      end
      if (accept) m_valid = 0;
      m_busy = m_active || m_par_phase;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      check("model word_out", 32'(word_out), 32'(m_word));
      check("model word_valid", 32'(word_valid), 32'(m_valid));
      check("model busy", 32'(busy), 32'(m_busy));
      check("model overrun", 32'(overrun), 32'(m_overrun));
      check("model parity_err", 32'(parity_err), 32'(m_perr));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic consume();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
  endtask

  // stream[7] is sent first.
  task automatic send_frame(input bit msb, input logic [7:0] stream, input int gap,
                            input bit chk_early, input bit last_ready);
    start = 1'b1;
    msb_first = msb;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_in = stream[7-i];
      bit_valid = 1'b1;
`ifndef RX_PARITY_CHECK_EN
      if (i == 7) word_ready = last_ready;
`endif
      step();
      bit_valid = 1'b0;
      word_ready = 1'b0;
`ifdef RX_PARITY_CHECK_EN
      if (chk_early) check("early word_valid", 32'(word_valid), 32'd0);
`else
      if (chk_early && i < 7) check("early word_valid", 32'(word_valid), 32'd0);
`endif
      if (i < 7) for (int g = 0; g < gap; g++) step();
    end
`ifdef RX_PARITY_CHECK_EN
    bit_in = (^stream) ^ par_flip;
    bit_valid = 1'b1;
    word_ready = last_ready;
    step();
    bit_valid = 1'b0;
    word_ready = 1'b0;
`endif
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk_on = 1'b1;
    check("reset word_out", 32'(word_out), 32'h0);
    check("reset word_valid", 32'(word_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);

    // MSB-first B2
    send_frame(1'b1, 8'hB2, 0, 1'b0, 1'b0);
    check("t1 word_out", 32'(word_out), 32'hB2);
    check("t1 word_valid", 32'(word_valid), 32'h1);
    check("t1 busy", 32'(busy), 32'h0);
    check("t1 model pin", 32'(m_word), 32'hB2);
    consume();
    check("t1 drained", 32'(word_valid), 32'h0);

    // LSB-first of the same stream
    send_frame(1'b0, 8'hB2, 0, 1'b0, 1'b0);
    check("t2 word_out", 32'(word_out), 32'h4D);
    check("t2 model pin", 32'(m_word), 32'h4D);

    // Word completes in the same cycle the held word is accepted
    send_frame(1'b0, 8'h3C, 0, 1'b0, 1'b1);
    check("sim word_out", 32'(word_out), 32'h3C);
    check("sim word_valid", 32'(word_valid), 32'h1);
    check("sim overrun", 32'(overrun), 32'h0);
    consume();

    // Gapped stream
    send_frame(1'b1, 8'hB2, 3, 1'b1, 1'b0);
    check("t3 word_out", 32'(word_out), 32'hB2);
    check("t3 word_valid", 32'(word_valid), 32'h1);

    // Overrun with B2 still held
    send_frame(1'b1, 8'h0F, 0, 1'b0, 1'b0);
    check("t4 word_out held", 32'(word_out), 32'hB2);
    check("t4 overrun", 32'(overrun), 32'h1);
    check("t4 model pin", 32'(m_overrun), 32'h1);
    consume();
    check("t4 drained", 32'(word_valid), 32'h0);
    check("t4 overrun sticky", 32'(overrun), 32'h1);

    // Abort after three bits, then a full A5 frame
    start = 1'b1; msb_first = 1'b0; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1; step();
    end
    bit_valid = 1'b0;
    send_frame(1'b1, 8'hA5, 0, 1'b0, 1'b0);
    check("t5 word_out", 32'(word_out), 32'hA5);
    check("t5 model pin", 32'(m_word), 32'hA5);

    // Reset mid-frame
    start = 1'b1; msb_first = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1; step();
    end
    bit_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("t5 rst word_out", 32'(word_out), 32'h0);
    check("t5 rst word_valid", 32'(word_valid), 32'h0);
    check("t5 rst busy", 32'(busy), 32'h0);
    check("t5 rst overrun", 32'(overrun), 32'h0);
    step();

`ifdef RX_PARITY_CHECK_EN
    par_flip = 1'b1;
    send_frame(1'b1, 8'hB2, 0, 1'b1, 1'b0);
    check("t6 parity_err set", 32'(parity_err), 32'h1);
    check("t6 word_valid", 32'(word_valid), 32'h1);
    check("t6 word_out", 32'(word_out), 32'hB2);
    consume();
    par_flip = 1'b0;
    send_frame(1'b1, 8'hB2, 0, 1'b1, 1'b0);
    check("t6 parity_err clear", 32'(parity_err), 32'h0);
    check("t6 word_valid 2", 32'(word_valid), 32'h1);
    consume();
`endif

    step();
    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
